tr_mux_seq: RTL and testbench

Parametrised, sequenced successor of the transfer-select mux. It picks one signed fixed-point word out of `LEN_TRANSFER` transfer lanes and can hold a manually loaded select or walk the lanes automatically. The auto walk runs from a programmable base, with a programmable stride and beat count, and wraps modulo `LEN_TRANSFER`. It sits between the transfer buffer lanes and the downstream consumer, and presents each selected word with a valid/ready handshake and a completion pulse.

---
 rtl/tr_mux_seq.sv | 159 +++++++++++++++
 tb/tb_tr_mux_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tr_mux_seq.sv
// tr_mux_seq: picks one signed fixed-point word out of LEN_TRANSFER lanes.
// The select is either loaded manually while idle, or walked automatically
// from a base with a fixed stride for a given number of beats. The walk wraps
// modulo LEN_TRANSFER. Each beat is offered to the consumer with valid/ready.
// done_o pulses after the last beat is accepted. err_o pulses when a request
// is rejected.
module tr_mux_seq #(
    parameter int I_WIDTH          = 8,
    parameter int F_WIDTH          = 8,
    parameter int LEN_TRANSFER     = 10,
    parameter int MAX_LEN_TRANSFER = 10,
    parameter int SEL_MUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER),
    parameter int CNT_WIDTH        = SEL_MUX_TR_WIDTH + 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [(I_WIDTH+F_WIDTH)*LEN_TRANSFER-1:0]     tr_data_i,
    input  logic [SEL_MUX_TR_WIDTH-1:0]                   sel_mux_tr_i,
    input  logic                                          sel_mux_tr_ld_i,
    input  logic                                          start_i,
    input  logic [SEL_MUX_TR_WIDTH-1:0]                   base_i,
    input  logic [SEL_MUX_TR_WIDTH-1:0]                   stride_i,
    input  logic [CNT_WIDTH-1:0]                          count_i,
    input  logic                                          tr_ready_i,
    output logic                                          tr_valid_o,
    output logic signed [I_WIDTH+F_WIDTH-1:0]             tr_data_o,
    output logic [SEL_MUX_TR_WIDTH-1:0]                   sel_mux_tr_o,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          err_o
);

    localparam int W  = I_WIDTH + F_WIDTH;
    localparam int SW = SEL_MUX_TR_WIDTH;
    localparam int CW = CNT_WIDTH;

    // Lane count widened by one bit so select/base/stride compares and the
    // select+stride sum can never overflow.
    localparam logic [SW:0] LEN_EXT = (SW+1)'(LEN_TRANSFER);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [SW-1:0]   stride_q, stride_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic signed [W-1:0] lane [LEN_TRANSFER];
    logic [SW:0]         sel_sum;
    logic [SW:0]         sel_wrap;
    logic                start_bad;
    logic                handshake;

    // Split the flat lane bus into an indexable array.
    generate
        for (genvar gi = 0; gi < LEN_TRANSFER; gi++) begin : g_lane
            assign lane[gi] = tr_data_i[gi*W +: W];
        end
    endgenerate

    // Next lane of the walk: one conditional subtract suffices because both
    // operands are already below LEN_TRANSFER.
    assign sel_sum  = {1'b0, sel_q} + {1'b0, stride_q};
    assign sel_wrap = (sel_sum >= LEN_EXT) ? (sel_sum - LEN_EXT) : sel_sum;

    assign start_bad = ({1'b0, base_i} >= LEN_EXT) || (stride_i == '0) ||
                       ({1'b0, stride_i} >= LEN_EXT) || (count_i == '0);
    assign handshake = valid_q && tr_ready_i;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rem_q    <= '0;
            stride_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
            stride_q <= stride_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: request handling in IDLE, beat stepping in RUN.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rem_d    = rem_q;
        stride_d = stride_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // start wins over a simultaneous manual load
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d    = base_i;
                        rem_d    = count_i;
                        stride_d = stride_i;
                        valid_d  = 1'b1;
                        state_d  = RUN;
                    end
                end else if (sel_mux_tr_ld_i) begin
                    if ({1'b0, sel_mux_tr_i} < LEN_EXT) begin
                        sel_d = sel_mux_tr_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    if (rem_q == CW'(1)) begin
                        // last beat: keep the final lane selected
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - CW'(1);
                        sel_d = SW'(sel_wrap);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: data follows the registered select in every state.
    always_comb begin
        busy_o       = (state_q == RUN);
        tr_valid_o   = valid_q;
        done_o       = done_q;
        err_o        = err_q;
        sel_mux_tr_o = sel_q;
        tr_data_o    = '0;
        if ({1'b0, sel_q} < LEN_EXT) begin
            tr_data_o = lane[sel_q];
        end
    end

endmodule

// File: tb/tb_tr_mux_seq.sv
// Bench for tr_mux_seq: directed scenarios plus randomized sequences, all
// checked against a lane list computed as (base + k*stride) mod LEN.
module tb_tr_mux_seq;

    localparam int IW  = 8;
    localparam int FW  = 8;
    localparam int W   = IW + FW;
    localparam int LEN = 10;
    localparam int SW  = 4;
    localparam int CW  = 5;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b0;
    logic [W*LEN-1:0]        tr_data_i = '0;
    logic [SW-1:0]           sel_mux_tr_i = '0;
    logic                    sel_mux_tr_ld_i = 1'b0;
    logic                    start_i = 1'b0;
    logic [SW-1:0]           base_i = '0;
    logic [SW-1:0]           stride_i = '0;
    logic [CW-1:0]           count_i = '0;
    logic                    tr_ready_i = 1'b0;
    logic                    tr_valid_o;
    logic signed [W-1:0]     tr_data_o;
    logic [SW-1:0]           sel_mux_tr_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] lane_val [LEN];
    int                  exp_lane [64];

    tr_mux_seq #(
        .I_WIDTH(IW), .F_WIDTH(FW), .LEN_TRANSFER(LEN), .MAX_LEN_TRANSFER(LEN)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tr_data_i(tr_data_i),
        .sel_mux_tr_i(sel_mux_tr_i), .sel_mux_tr_ld_i(sel_mux_tr_ld_i),
        .start_i(start_i), .base_i(base_i), .stride_i(stride_i),
        .count_i(count_i), .tr_ready_i(tr_ready_i), .tr_valid_o(tr_valid_o),
        .tr_data_o(tr_data_o), .sel_mux_tr_o(sel_mux_tr_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_lanes(input bit rnd);
        for (int i = 0; i < LEN; i++) begin
            lane_val[i] = rnd ? W'($urandom) : W'(100 + i);
            tr_data_i[i*W +: W] = lane_val[i];
        end
    endtask

    // Runs one sequence. ready at sample k is mask[k%32]. With noise set,
    // start/load are toggled during RUN and must be ignored silently.
    // Returns on the done cycle without clearing done.
    task automatic run_seq(input int b, input int s, input int c,
                           input logic [31:0] mask, input bit noise,
                           input bit ld_with_start, input int ld_val);
        int idx = 0;
        int smp = 0;
        bit fin = 0;
        bit rdy;
        logic [23:0] exp_v;
        for (int k = 0; k < c; k++) exp_lane[k] = (b + k * s) % LEN;
        base_i = SW'(b); stride_i = SW'(s); count_i = CW'(c);
        start_i = 1'b1; sel_mux_tr_ld_i = ld_with_start; sel_mux_tr_i = SW'(ld_val);
        tick();
        start_i = 1'b0; sel_mux_tr_ld_i = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (idx < c) begin
                exp_v = {4'b1100, SW'(exp_lane[idx]), lane_val[exp_lane[idx]]};
                total++;
                if ({busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o} !== exp_v) begin
                    bad++;
                    $display("FAIL beat%0d base=%0d stride=%0d: got %h want %h",
                             idx, b, s,
                             {busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o}, exp_v);
                end
                rdy = mask[smp % 32];
                tr_ready_i = rdy;
                if (noise) begin
                    start_i = 1'($urandom);
                    sel_mux_tr_ld_i = 1'($urandom);
                    sel_mux_tr_i = 4'd2;
                    base_i = SW'($urandom);
                end
                smp++;
                tick();
                if (rdy) idx++;
            end else begin
                start_i = 1'b0; sel_mux_tr_ld_i = 1'b0; tr_ready_i = 1'b0;
                exp_v = {4'b0010, SW'(exp_lane[c-1]), lane_val[exp_lane[c-1]]};
                total++;
                if ({busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o} !== exp_v) begin
                    bad++;
                    $display("FAIL done base=%0d stride=%0d count=%0d: got %h want %h",
                             b, s, c,
                             {busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o}, exp_v);
                end
                fin = 1;
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL seq_timeout: got beats=%0d want %0d", idx, c);
        end
        start_i = 1'b0; sel_mux_tr_ld_i = 1'b0;
        $display("seq base=%0d stride=%0d count=%0d samples=%0d", b, s, c, smp);
    endtask

    task automatic test_reset();
        set_lanes(0);
        rst_i = 1'b1;
        tick();
        total++;
        if ({busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o} !== {8'h00, 16'sd100}) begin
            bad++;
            $display("FAIL reset: got %h want %h",
                     {busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o}, {8'h00, 16'sd100});
        end
        rst_i = 1'b0;
        tick();
        $display("reset checked");
    endtask

    task automatic test_basic();
        run_seq(3, 1, 4, 32'hFFFF_FFFF, 0, 0, 0);
        tick();
        total++;
        if ({busy_o, tr_valid_o, done_o} !== 3'b000) begin
            bad++;
            $display("FAIL basic_after_done: got %b want 000", {busy_o, tr_valid_o, done_o});
        end
    endtask

    task automatic test_wrap();
        run_seq(8, 3, 4, 32'hFFFF_FFFF, 0, 0, 0);
        tick();
    endtask

    task automatic test_backpressure();
        // ready low on the 2nd and 3rd samples: lane 4 is held three cycles
        run_seq(3, 1, 4, 32'hFFFF_FFF9, 0, 0, 0);
        tick();
    endtask

    task automatic test_errors();
        int bases [4]   = '{12, 0, 0, 2};
        int strides [4] = '{1, 0, 10, 1};
        int counts [4]  = '{3, 3, 3, 0};
        for (int i = 0; i < 4; i++) begin
            base_i = SW'(bases[i]); stride_i = SW'(strides[i]); count_i = CW'(counts[i]);
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            total++;
            if ({busy_o, tr_valid_o, err_o} !== 3'b001) begin
                bad++;
                $display("FAIL bad_start%0d: got %b want 001", i, {busy_o, tr_valid_o, err_o});
            end
            tick();
            total++;
            if ({busy_o, err_o} !== 2'b00) begin
                bad++;
                $display("FAIL err_pulse%0d: got %b want 00", i, {busy_o, err_o});
            end
            $display("rejected start base=%0d stride=%0d count=%0d", bases[i], strides[i], counts[i]);
        end
    endtask

    task automatic test_loads();
        sel_mux_tr_i = 4'd5; sel_mux_tr_ld_i = 1'b1;
        tick();
        sel_mux_tr_ld_i = 1'b0;
        total++;
        if ({err_o, sel_mux_tr_o, tr_data_o} !== {1'b0, 4'd5, lane_val[5]}) begin
            bad++;
            $display("FAIL load5: got %h want %h", {err_o, sel_mux_tr_o, tr_data_o},
                     {1'b0, 4'd5, lane_val[5]});
        end
        sel_mux_tr_i = 4'd12; sel_mux_tr_ld_i = 1'b1;
        tick();
        sel_mux_tr_ld_i = 1'b0;
        total++;
        if ({err_o, sel_mux_tr_o} !== {1'b1, 4'd5}) begin
            bad++;
            $display("FAIL load12: got %h want %h", {err_o, sel_mux_tr_o}, {1'b1, 4'd5});
        end
        tick();
        $display("loads checked");
        // load of 2 and starts during RUN are ignored and raise no error
        run_seq(1, 2, 6, 32'hFFFF_FFFF, 1, 0, 0);
        tick();
        // start and load together: the sequence starts from the base
        run_seq(6, 1, 3, 32'hFFFF_FFFF, 0, 1, 7);
        tick();
    endtask

    task automatic test_reset_mid();
        base_i = 4'd0; stride_i = 4'd1; count_i = 5'd8; tr_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        total++;
        if ({busy_o, sel_mux_tr_o} !== {1'b1, 4'd1}) begin
            bad++;
            $display("FAIL mid_beat2: got %h want %h", {busy_o, sel_mux_tr_o}, {1'b1, 4'd1});
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++;
        if ({busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o} !== {8'h00, lane_val[0]}) begin
            bad++;
            $display("FAIL mid_reset: got %h want %h",
                     {busy_o, tr_valid_o, done_o, err_o, sel_mux_tr_o, tr_data_o}, {8'h00, lane_val[0]});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({busy_o, tr_valid_o, done_o} !== 3'b000) begin
                bad++;
                $display("FAIL mid_quiet%0d: got %b want 000", i, {busy_o, tr_valid_o, done_o});
            end
        end
        tr_ready_i = 1'b0;
        $display("reset mid-sequence checked");
        run_seq(2, 5, 3, 32'hFFFF_FFFF, 0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        run_seq(0, 1, 2, 32'hFFFF_FFFF, 0, 0, 0);
        run_seq(9, 4, 5, 32'hFFFF_FFFF, 0, 0, 0);
        run_seq(4, 9, 3, 32'hFFFF_FFFF, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        set_lanes(1);
        for (int n = 0; n < 20; n++) begin
            run_seq($urandom_range(0, LEN-1), $urandom_range(1, LEN-1),
                    $urandom_range(1, 12), $urandom | 32'h1, n[0], 0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_errors();
        test_loads();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
